// File: rtl/mips_cache_pkg.sv
// rtl/mips_cache_pkg.sv - shared types and address/byte helpers for the MIPS data cache
package mips_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    FILL,
    FLUSH,
    DONE
  } state_t;

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int index_bits);
    return addr >> (index_bits + 2);
  endfunction

  function automatic logic [31:0] index_of(input logic [31:0] addr, input int index_bits);
    return (addr >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  // Byte [0] of the core's byte array is the most significant byte of the word.
  function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[8*(3-i) +: 8];
  endfunction

endpackage

// File: rtl/dcache_store.sv
// rtl/dcache_store.sv - line storage: valid/dirty/tag/data, one async read port, one sync write port
module dcache_store #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_W      = 25
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_dirty,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [31:0]           wr_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      words [LINES];

  // Every write (fill, hit store, flush clean) leaves the line valid.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = words[rd_idx];

endmodule

// File: rtl/mips_dcache.sv
// rtl/mips_dcache.sv - direct-mapped write-back write-allocate data cache with halt-time flush
module mips_dcache
  import mips_cache_pkg::*;
#(
  parameter int INDEX_BITS  = 5,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [7:0]  core_wdata [0:3],
  output logic [7:0]  core_rdata [0:3],
  output logic        core_stall,
  input  logic        halted_in,
  output logic        flush_done,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in [0:3],
  input  logic [7:0]  mem_data_out [0:3],
  output logic        mem_write_en
);
  localparam int TAG_W = 30 - INDEX_BITS;
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(MEM_LATENCY - 1);
  localparam logic [INDEX_BITS-1:0] IDX_LAST = '1;

  state_t state, state_n;
  logic [LAT_W-1:0]      lat_cnt, lat_n;
  logic [INDEX_BITS-1:0] flush_idx, flush_idx_n;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] req_idx, rd_idx;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [31:0]           rd_data;

  logic                  wr_en, wr_dirty;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      wr_tag;
  logic [31:0]           wr_data;

  logic [31:0] mem_word, wdata_word, fill_word;
  logic        hit, lat_last, victim_dirty;

  assign req_tag    = TAG_W'(tag_of(core_addr, INDEX_BITS));
  assign req_idx    = INDEX_BITS'(index_of(core_addr, INDEX_BITS));
  assign rd_idx     = (state == FLUSH) ? flush_idx : req_idx;
  assign hit        = core_req && rd_valid && (rd_tag == req_tag);
  assign victim_dirty = rd_valid && rd_dirty;
  assign lat_last   = (lat_cnt == LAT_LAST);
  assign wdata_word = pack_word(core_wdata[0], core_wdata[1], core_wdata[2], core_wdata[3]);
  assign fill_word  = pack_word(mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]);
  assign flush_done = (state == DONE);

  for (genvar g = 0; g < 4; g++) begin : g_bytes
    assign core_rdata[g]  = byte_of(rd_data, g);
    assign mem_data_in[g] = byte_of(mem_word, g);
  end

  dcache_store #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk      (clk),
    .rst_b    (rst_b),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      flush_idx <= '0;
    end else begin
      state     <= state_n;
      lat_cnt   <= lat_n;
      flush_idx <= flush_idx_n;
    end
  end

  always_comb begin
    state_n      = state;
    lat_n        = lat_cnt;
    flush_idx_n  = flush_idx;
    wr_en        = 1'b0;
    wr_idx       = req_idx;
    wr_dirty     = 1'b0;
    wr_tag       = rd_tag;
    wr_data      = rd_data;
    core_stall   = 1'b0;
    mem_addr     = '0;
    mem_word     = '0;
    mem_write_en = 1'b0;
    unique case (state)
      IDLE: begin
        lat_n = '0;
        // A halting core's pending access is dropped, not serviced.
        if (halted_in) begin
          state_n     = FLUSH;
          flush_idx_n = '0;
          core_stall  = core_req;
        end else if (core_req) begin
          if (hit) begin
            if (core_we) begin
              wr_en    = 1'b1;
              wr_dirty = 1'b1;
              wr_data  = wdata_word;
            end
          end else begin
            core_stall = 1'b1;
            state_n    = victim_dirty ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        core_stall   = 1'b1;
        mem_addr     = {rd_tag, req_idx, 2'b00};
        mem_word     = rd_data;
        mem_write_en = 1'b1;
        if (lat_last) begin
          state_n = FILL;
          lat_n   = '0;
        end else begin
          lat_n = lat_cnt + 1'b1;
        end
      end
      FILL: begin
        core_stall = 1'b1;
        mem_addr   = {core_addr[31:2], 2'b00};
        if (lat_last) begin
          wr_en   = 1'b1;
          wr_tag  = req_tag;
          wr_data = fill_word;
          state_n = IDLE;
          lat_n   = '0;
        end else begin
          lat_n = lat_cnt + 1'b1;
        end
      end
      FLUSH: begin
        core_stall = 1'b1;
        wr_idx     = flush_idx;
        if (victim_dirty) begin
          mem_addr     = {rd_tag, flush_idx, 2'b00};
          mem_word     = rd_data;
          mem_write_en = 1'b1;
          lat_n        = lat_cnt + 1'b1;
        end
        // Clean lines take one cycle; dirty ones advance after the last write cycle.
        if (!victim_dirty || lat_last) begin
          lat_n = '0;
          wr_en = victim_dirty;
          if (flush_idx == IDX_LAST) state_n = DONE;
          else                       flush_idx_n = flush_idx + 1'b1;
        end
      end
      DONE: begin
        core_stall = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_dcache.sv
// tb/tb_mips_dcache.sv - directed table and sequence checks for mips_dcache
module tb_mips_dcache;

  localparam int L = 4;

  logic        clk;
  logic        rst_b;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [7:0]  core_wdata [0:3];
  logic [7:0]  core_rdata [0:3];
  logic        core_stall;
  logic        halted_in;
  logic        flush_done;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in [0:3];
  logic [7:0]  mem_data_out [0:3];
  logic        mem_write_en;

  mips_dcache #(.INDEX_BITS(5), .MEM_LATENCY(L)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .core_stall  (core_stall),
    .halted_in   (halted_in),
    .flush_done  (flush_done),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency memory: a write commits only after L consecutive strobe cycles.
  logic [31:0] mem [0:255];
  logic [31:0] bursts [0:15];
  logic [3:0]  burst_cnt = 4'd0;
  int          wr_run = 0;
  logic        init_done = 1'b0;

  always_comb begin
    for (int i = 0; i < 4; i++) mem_data_out[i] = mem[mem_addr[9:2]][8*(3-i) +: 8];
  end

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[16]   <= 32'h11223344;
      mem[48]   <= 32'h55667788;
      init_done <= 1'b1;
    end else if (!rst_b) begin
      wr_run <= 0;
    end else if (mem_write_en) begin
      if (wr_run == L - 1) begin
        mem[mem_addr[9:2]] <= {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
        bursts[burst_cnt]  <= mem_addr;
        burst_cnt          <= burst_cnt + 4'd1;
        wr_run             <= 0;
      end else begin
        wr_run <= wr_run + 1;
      end
    end else begin
      wr_run <= 0;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_wdata(input logic [31:0] w);
    for (int i = 0; i < 4; i++) core_wdata[i] = w[8*(3-i) +: 8];
  endtask

  function automatic logic [31:0] rd_word();
    return {core_rdata[0], core_rdata[1], core_rdata[2], core_rdata[3]};
  endfunction

  function automatic logic [31:0] wd_word();
    return {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
  endfunction

  // Holds a request until it completes; returns stall cycles and the data seen on the hit cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rd);
    core_req  = 1'b1;
    core_we   = we;
    core_addr = addr;
    set_wdata(wd);
    stalls = 0;
    @(negedge clk);
    while (core_stall && stalls < 50) begin
      stalls++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    rd = rd_word();
    @(posedge clk); #1;
    core_req = 1'b0;
    core_we  = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        wen;
    logic [2:0]  mask;   // [0] mem_addr, [1] mem_data_in, [2] core_rdata
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic stall, input logic wen,
                              input logic [2:0] mask, input logic [31:0] maddr,
                              input logic [31:0] mwd, input logic [31:0] rdata);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.stall = stall;
    v.wen = wen; v.mask = mask; v.maddr = maddr; v.mwd = mwd; v.rdata = rdata;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    int          stalls;
    int          cnt;
    logic [31:0] rd;
    logic [3:0]  b0;
    logic        bad_access;

    tbl[0] = mk(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    for (int i = 1; i <= 4; i++)
      tbl[i] = mk(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 3'b001, 32'h40, 32'h0, 32'h0);
    tbl[5] = mk(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 3'b100, 32'h0, 32'h0, 32'h11223344);
    tbl[6] = mk(1'b1, 1'b1, 32'h40, 32'hAABBCCDD, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    tbl[7] = mk(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 3'b100, 32'h0, 32'h0, 32'hAABBCCDD);
    tbl[8] = mk(1'b1, 1'b0, 32'hC0, 32'h0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    for (int i = 9; i <= 12; i++)
      tbl[i] = mk(1'b1, 1'b0, 32'hC0, 32'h0, 1'b1, 1'b1, 3'b011, 32'h40, 32'hAABBCCDD, 32'h0);
    for (int i = 13; i <= 16; i++)
      tbl[i] = mk(1'b1, 1'b0, 32'hC0, 32'h0, 1'b1, 1'b0, 3'b001, 32'hC0, 32'h0, 32'h0);
    tbl[17] = mk(1'b1, 1'b0, 32'hC0, 32'h0, 1'b0, 1'b0, 3'b100, 32'h0, 32'h0, 32'h55667788);

    rst_b = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; halted_in = 1'b0;
    set_wdata(32'h0);

    @(negedge clk);
    chk("reset flush_done", 32'(flush_done), 32'h0);
    chk("reset mem_write_en", 32'(mem_write_en), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_data_in", wd_word(), 32'h0);
    chk("reset core_stall", 32'(core_stall), 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;

    // Clean fill, hit store, hit load, dirty conflict miss, cycle by cycle.
    for (int i = 0; i < 18; i++) begin
      core_req  = tbl[i].req;
      core_we   = tbl[i].we;
      core_addr = tbl[i].addr;
      set_wdata(tbl[i].wdata);
      @(negedge clk);
      chk($sformatf("row%0d core_stall", i), 32'(core_stall), 32'(tbl[i].stall));
      chk($sformatf("row%0d mem_write_en", i), 32'(mem_write_en), 32'(tbl[i].wen));
      if (tbl[i].mask[0]) chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].maddr);
      if (tbl[i].mask[1]) chk($sformatf("row%0d mem_data_in", i), wd_word(), tbl[i].mwd);
      if (tbl[i].mask[2]) chk($sformatf("row%0d core_rdata", i), rd_word(), tbl[i].rdata);
      @(posedge clk); #1;
    end
    core_req = 1'b0;
    chk("writeback landed in memory", mem[16], 32'hAABBCCDD);

    // Halt flush with dirty lines at indices 1 and 31.
    access(1'b1, 32'h04, 32'h01020304, stalls, rd);
    chk("store idx1 stalls", 32'(stalls), 32'd5);
    access(1'b1, 32'h7C, 32'hDEADBEEF, stalls, rd);
    chk("store idx31 stalls", 32'(stalls), 32'd5);
    b0 = burst_cnt;
    halted_in = 1'b1;
    @(negedge clk);
    chk("halt cycle flush_done", 32'(flush_done), 32'h0);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!flush_done) cnt++;
    end while (!flush_done && cnt < 200);
    chk("flush cycles", 32'(cnt), 32'd38);
    chk("flush burst count", 32'(burst_cnt - b0), 32'd2);
    chk("flush burst0 addr", bursts[b0], 32'h04);
    chk("flush burst1 addr", bursts[b0 + 4'd1], 32'h7C);
    chk("flushed idx1 data", mem[1], 32'h01020304);
    chk("flushed idx31 data", mem[31], 32'hDEADBEEF);
    halted_in = 1'b0;
    core_req  = 1'b1;
    core_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("done%0d flush_done", i), 32'(flush_done), 32'h1);
      chk($sformatf("done%0d core_stall", i), 32'(core_stall), 32'h1);
      chk($sformatf("done%0d mem_write_en", i), 32'(mem_write_en), 32'h0);
    end

    // Reset during the second writeback cycle abandons the write.
    @(posedge clk); #1;
    core_req = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("post-reset flush_done", 32'(flush_done), 32'h0);
    @(posedge clk); #1;
    access(1'b1, 32'h40, 32'h11111111, stalls, rd);
    chk("dirtying store stalls", 32'(stalls), 32'd5);
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 32'hC0;
    @(negedge clk);
    chk("dirty miss stall", 32'(core_stall), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb1 mem_write_en", 32'(mem_write_en), 32'h1);
    @(posedge clk); #1;
    chk("wb2 mem_write_en", 32'(mem_write_en), 32'h1);
    rst_b = 1'b0;
    core_req = 1'b0;
    #1;
    chk("async drop mem_write_en", 32'(mem_write_en), 32'h0);
    chk("async drop mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    access(1'b0, 32'h40, 32'h0, stalls, rd);
    chk("reload after abort stalls", 32'(stalls), 32'd5);
    chk("reload after abort data", rd, 32'hAABBCCDD);

    // Halt and a missing request in the same IDLE cycle.
    b0 = burst_cnt;
    core_req   = 1'b1;
    core_addr  = 32'hC0;
    halted_in  = 1'b1;
    bad_access = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      @(negedge clk);
      if (mem_write_en || mem_addr == 32'hC0) bad_access = 1'b1;
      if (!flush_done) cnt++;
    end while (!flush_done && cnt < 200);
    chk("halt+miss flush cycles", 32'(cnt), 32'd32);
    chk("halt+miss no memory access", 32'(bad_access), 32'h0);
    chk("halt+miss no bursts", 32'(burst_cnt - b0), 32'd0);
    core_req  = 1'b0;
    halted_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
